// File: rtl/calc2_port_responder.sv
// Calc2 single-port responder: two-cycle request capture feeding an in-order,
// fixed-latency response queue with one registered response per cycle.
module calc2_port_responder #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 2,
    parameter int LATENCY = 3
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    input  logic [TAG_W-1:0]  req_tag_in,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              proto_err
);
    localparam int DEPTH = 1 << TAG_W;
    localparam int CNT_W = TAG_W + 1;
    localparam int AGE_W = $clog2(LATENCY + 1);

    typedef enum logic {IDLE, OP2} state_t;

    state_t            st_q, st_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [1:0]        ent_resp_q [DEPTH];
    logic [1:0]        ent_resp_d [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [TAG_W-1:0]  ent_tag_q  [DEPTH];
    logic [TAG_W-1:0]  ent_tag_d  [DEPTH];
    logic [AGE_W-1:0]  ent_age_q  [DEPTH];
    logic [AGE_W-1:0]  ent_age_d  [DEPTH];
    logic [TAG_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        out_resp_q, out_resp_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              perr_q, perr_d;

    logic [DATA_W:0]   sum;
    logic [1:0]        res_resp;
    logic [DATA_W-1:0] res_data;
    logic              pop, push, full, dup;
    logic [TAG_W-1:0]  off;

    // Result of the latched command against operand 2 on the bus this cycle.
    always_comb begin
        sum      = {1'b0, op1_q} + {1'b0, req_data_in};
        res_resp = 2'd2;
        res_data = '0;
        case (cmd_q)
            4'd1: if (!sum[DATA_W]) begin
                res_resp = 2'd1;
                res_data = sum[DATA_W-1:0];
            end
            4'd2: if (req_data_in <= op1_q) begin
                res_resp = 2'd1;
                res_data = op1_q - req_data_in;
            end
            4'd5: begin
                res_resp = 2'd1;
                res_data = op1_q << req_data_in[4:0];
            end
            4'd6: begin
                res_resp = 2'd1;
                res_data = op1_q >> req_data_in[4:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        st_d       = st_q;
        cmd_d      = cmd_q;
        tag_d      = tag_q;
        op1_d      = op1_q;
        ent_resp_d = ent_resp_q;
        ent_data_d = ent_data_q;
        ent_tag_d  = ent_tag_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        perr_d     = perr_q;
        out_resp_d = '0;
        out_data_d = '0;
        out_tag_d  = '0;
        off        = '0;
        dup        = 1'b0;
        push       = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_age_q[i] != AGE_W'(LATENCY)) ent_age_d[i] = ent_age_q[i] + AGE_W'(1);
            else                                 ent_age_d[i] = ent_age_q[i];
        end

        pop = (cnt_q != '0) && (ent_age_q[rd_ptr_q] == AGE_W'(LATENCY));
        if (pop) begin
            out_resp_d = ent_resp_q[rd_ptr_q];
            out_data_d = ent_data_q[rd_ptr_q];
            out_tag_d  = ent_tag_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + TAG_W'(1);
        end

        // The head leaving this cycle neither occupies a slot nor counts as outstanding.
        full = (cnt_q == CNT_W'(DEPTH)) && !pop;
        for (int i = 0; i < DEPTH; i++) begin
            off = TAG_W'(i) - rd_ptr_q;
            if (({1'b0, off} < cnt_q) && !(pop && off == '0) && ent_tag_q[i] == tag_q)
                dup = 1'b1;
        end

        case (st_q)
            IDLE: if (req_cmd_in != 4'd0) begin
                cmd_d = req_cmd_in;
                tag_d = req_tag_in;
                op1_d = req_data_in;
                st_d  = OP2;
            end
            OP2: begin
                st_d = IDLE;
                push = !full;
                if (req_cmd_in != 4'd0 || full || dup) perr_d = 1'b1;
            end
            default: st_d = IDLE;
        endcase

        if (push) begin
            ent_resp_d[wr_ptr_q] = res_resp;
            ent_data_d[wr_ptr_q] = res_data;
            ent_tag_d[wr_ptr_q]  = tag_q;
            ent_age_d[wr_ptr_q]  = '0;
            wr_ptr_d             = wr_ptr_q + TAG_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            st_q       <= IDLE;
            cmd_q      <= '0;
            tag_q      <= '0;
            op1_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            out_resp_q <= '0;
            out_data_q <= '0;
            out_tag_q  <= '0;
            perr_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_resp_q[i] <= '0;
                ent_data_q[i] <= '0;
                ent_tag_q[i]  <= '0;
                ent_age_q[i]  <= '0;
            end
        end else begin
            st_q       <= st_d;
            cmd_q      <= cmd_d;
            tag_q      <= tag_d;
            op1_q      <= op1_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            out_resp_q <= out_resp_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
            perr_q     <= perr_d;
            ent_resp_q <= ent_resp_d;
            ent_data_q <= ent_data_d;
            ent_tag_q  <= ent_tag_d;
            ent_age_q  <= ent_age_d;
        end
    end

    assign out_resp  = out_resp_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_calc2_port_responder.sv
// Bench for calc2_port_responder: two instances (short and long latency) share
// one request stream and are compared each cycle against a transaction-level model.
module tb_calc2_port_responder;
    localparam int LA = 3;
    localparam int LB = 9;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_cmd_in = '0;
    logic [31:0] req_data_in = '0;
    logic [1:0]  req_tag_in = '0;
    logic [1:0]  o_resp [2];
    logic [31:0] o_data [2];
    logic [1:0]  o_tag  [2];
    logic        o_perr [2];

    always #5 c_clk = ~c_clk;

    calc2_port_responder #(.DATA_W(32), .TAG_W(2), .LATENCY(LA)) u_a (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .req_tag_in(req_tag_in), .out_resp(o_resp[0]), .out_data(o_data[0]),
        .out_tag(o_tag[0]), .proto_err(o_perr[0]));

    calc2_port_responder #(.DATA_W(32), .TAG_W(2), .LATENCY(LB)) u_b (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .req_tag_in(req_tag_in), .out_resp(o_resp[1]), .out_data(o_data[1]),
        .out_tag(o_tag[1]), .proto_err(o_perr[1]));

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        int          rt;     // edge index at which the response becomes visible
    } ent_t;

    ent_t        mq [2][16];
    int          mcnt [2];
    int          lat  [2];
    bit          mperr [2];
    logic [35:0] mexp [2];
    bit          m_op2;
    logic [3:0]  m_cmd;
    logic [31:0] m_op1;
    logic [1:0]  m_tag;
    int          e = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else n_pass++;
    endtask

    function automatic void calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [1:0] r, output logic [31:0] d);
        logic [63:0] s;
        r = 2'd2;
        d = '0;
        case (c)
            4'd1: begin
                s = {32'd0, a} + {32'd0, b};
                if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
            end
            4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << (b % 32); end
            4'd6: begin r = 2'd1; d = a >> (b % 32); end
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]  = 0;
            mperr[k] = 1'b0;
            mexp[k]  = '0;
        end
        m_op2 = 1'b0;
    endtask

    // One clock edge of the reference: retire what is due, then consume the request bus.
    task automatic model_edge(input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
        logic [1:0]  r;
        logic [31:0] rd;
        for (int k = 0; k < 2; k++) begin
            mexp[k] = '0;
            if (mcnt[k] > 0 && mq[k][0].rt == e) begin
                mexp[k] = {mq[k][0].resp, mq[k][0].data, mq[k][0].tag};
                for (int j = 1; j < mcnt[k]; j++) mq[k][j-1] = mq[k][j];
                mcnt[k]--;
            end
        end
        if (m_op2) begin
            m_op2 = 1'b0;
            calc(m_cmd, m_op1, d, r, rd);
            for (int k = 0; k < 2; k++) begin
                if (c != 4'd0) mperr[k] = 1'b1;
                if (mcnt[k] >= 4) mperr[k] = 1'b1;
                else begin
                    for (int j = 0; j < mcnt[k]; j++)
                        if (mq[k][j].tag == m_tag) mperr[k] = 1'b1;
                    mq[k][mcnt[k]].resp = r;
                    mq[k][mcnt[k]].data = rd;
                    mq[k][mcnt[k]].tag  = m_tag;
                    mq[k][mcnt[k]].rt   = e + lat[k] + 1;
                    mcnt[k]++;
                end
            end
        end else if (c != 4'd0) begin
            m_op2 = 1'b1;
            m_cmd = c;
            m_op1 = d;
            m_tag = t;
        end
    endtask

    task automatic check_outs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out%0d@%0d", k, e), {o_resp[k], o_data[k], o_tag[k]}, mexp[k]);
            chk($sformatf("perr%0d@%0d", k, e), o_perr[k], mperr[k]);
        end
    endtask

    task automatic tick(input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
        req_cmd_in  = c;
        req_data_in = d;
        req_tag_in  = t;
        @(posedge c_clk);
        e++;
        model_edge(c, d, t);
        @(negedge c_clk);
        check_outs();
    endtask

    task automatic txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] t);
        tick(c, a, t);
        tick(4'd0, b, 2'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(4'd0, 32'd0, 2'd0);
    endtask

    // Called at a falling edge; check_now also verifies the asynchronous clear.
    task automatic do_reset(input bit check_now);
        reset       = 1'b0;
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
        #1;
        if (check_now)
            for (int k = 0; k < 2; k++)
                chk($sformatf("async_rst%0d", k), {o_resp[k], o_data[k], o_tag[k], o_perr[k]}, 64'd0);
        model_reset();
        repeat (2) begin
            @(posedge c_clk);
            e++;
        end
        @(negedge c_clk);
        check_outs();
        reset = 1'b1;
    endtask

    initial begin
        lat[0] = LA;
        lat[1] = LB;
        do_reset(1'b0);

        txn(4'd1, 32'h0000_0005, 32'h0000_0007, 2'd2);
        idle(12);

        txn(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd1);
        txn(4'd2, 32'd3, 32'd5, 2'd0);
        txn(4'd2, 32'd5, 32'd3, 2'd3);
        idle(12);

        txn(4'd5, 32'h8000_0001, 32'd33, 2'd0);
        txn(4'd6, 32'h8000_0000, 32'd31, 2'd1);
        txn(4'd4, 32'h1234_5678, 32'h9ABC_DEF0, 2'd2);
        idle(12);

        for (int i = 0; i < 4; i++) txn(4'd1, 32'(i * 100), 32'(i + 1), 2'(i));
        idle(14);

        // Four outstanding in the long-latency instance, then a fifth.
        for (int i = 0; i < 4; i++) txn(4'd1, 32'(i), 32'd10, 2'(i));
        txn(4'd1, 32'd77, 32'd1, 2'd1);
        idle(16);
        do_reset(1'b1);

        tick(4'd1, 32'd20, 2'd2);
        tick(4'd1, 32'd22, 2'd0);
        idle(12);

        // Reset while requests are queued and an operand-2 cycle is pending.
        txn(4'd2, 32'd10, 32'd3, 2'd0);
        txn(4'd1, 32'd4, 32'd4, 2'd1);
        txn(4'd6, 32'hF0, 32'd4, 2'd2);
        tick(4'd1, 32'd9, 2'd3);
        do_reset(1'b1);
        idle(15);
        txn(4'd1, 32'd1, 32'd1, 2'd0);
        idle(12);

        for (int n = 0; n < 250; n++) begin
            logic [3:0]  c;
            logic [3:0]  c2;
            logic [31:0] a;
            logic [31:0] b;
            case ($urandom_range(0, 9))
                0, 1:    c = 4'd1;
                2, 3:    c = 4'd2;
                4:       c = 4'd5;
                5:       c = 4'd6;
                6:       c = 4'($urandom_range(1, 15));
                default: c = 4'($urandom_range(0, 1) ? 1 : 2);
            endcase
            a  = ($urandom_range(0, 3) == 0) ? 32'(32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            c2 = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            tick(c, a, 2'($urandom_range(0, 3)));
            tick(c2, b, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
            if (n % 80 == 79) do_reset(1'b1);
        end
        idle(14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
